// File: rtl/warp_fetch_sched_if.sv
// Fetch-scheduler bus: launch/redirect/stall controls in, per-warp PCs and dual one-hot grants out.
interface warp_fetch_sched_if #(
    parameter int NUM_WARPS = 8
);
    localparam int IDX_W = $clog2(NUM_WARPS);

    logic [NUM_WARPS-1:0] PC_Valid;
    logic [NUM_WARPS-1:0] IBuf_Space_IB_IF;
    logic                 Stall_IF;
    logic                 Init_Wen;
    logic [IDX_W-1:0]     Init_WarpID;
    logic [31:0]          Init_PC;
    logic [NUM_WARPS-1:0] UpdatePC_Wen_SIMT_IF;
    logic [31:0]          UpdatePC_SIMT_IF;
    logic [31:0]          PC0_PC_IF, PC1_PC_IF, PC2_PC_IF, PC3_PC_IF;
    logic [31:0]          PC4_PC_IF, PC5_PC_IF, PC6_PC_IF, PC7_PC_IF;
    logic [NUM_WARPS-1:0] GRT_raw_1_RR_IF;
    logic [NUM_WARPS-1:0] GRT_raw_2_RR_IF;

    modport master (
        output PC_Valid, IBuf_Space_IB_IF, Stall_IF, Init_Wen, Init_WarpID, Init_PC,
               UpdatePC_Wen_SIMT_IF, UpdatePC_SIMT_IF,
        input  PC0_PC_IF, PC1_PC_IF, PC2_PC_IF, PC3_PC_IF,
               PC4_PC_IF, PC5_PC_IF, PC6_PC_IF, PC7_PC_IF,
               GRT_raw_1_RR_IF, GRT_raw_2_RR_IF
    );

    modport slave (
        input  PC_Valid, IBuf_Space_IB_IF, Stall_IF, Init_Wen, Init_WarpID, Init_PC,
               UpdatePC_Wen_SIMT_IF, UpdatePC_SIMT_IF,
        output PC0_PC_IF, PC1_PC_IF, PC2_PC_IF, PC3_PC_IF,
               PC4_PC_IF, PC5_PC_IF, PC6_PC_IF, PC7_PC_IF,
               GRT_raw_1_RR_IF, GRT_raw_2_RR_IF
    );
endinterface

// File: rtl/warp_fetch_sched.sv
// Per-warp PC file with round-robin fetch arbiter; define FETCH_DUAL_ISSUE_EN for a second grant per cycle.
// NUM_WARPS is expected to be 8 (a power of two, so pointer arithmetic wraps naturally).
module warp_fetch_sched #(
    parameter int NUM_WARPS = 8,
    parameter int FETCH_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    warp_fetch_sched_if.slave    bus
);
    localparam int         IDX_W = $clog2(NUM_WARPS);
    localparam logic [1:0] LAT   = 2'(FETCH_LAT);

    logic [31:0]          r_pc  [NUM_WARPS];
    logic [1:0]           r_cnt [NUM_WARPS];
    logic [IDX_W-1:0]     r_rr_ptr;

    logic [NUM_WARPS-1:0] w_init_hit;
    logic [NUM_WARPS-1:0] w_elig;
    logic [NUM_WARPS-1:0] w_grt1;
    logic [NUM_WARPS-1:0] w_grt2;
    logic [NUM_WARPS-1:0] w_grt_any;
    logic [IDX_W-1:0]     w_scan_idx;
    logic [IDX_W-1:0]     w_g1_idx;
    logic                 w_g1_vld;
`ifdef FETCH_DUAL_ISSUE_EN
    logic [IDX_W-1:0]     w_g2_idx;
    logic                 w_g2_vld;
`endif

    always_comb begin
        w_init_hit = '0;
        w_elig     = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            w_init_hit[i] = bus.Init_Wen && (bus.Init_WarpID == IDX_W'(i));
            w_elig[i]     = bus.PC_Valid[i] && bus.IBuf_Space_IB_IF[i] && (r_cnt[i] == 2'd0)
                            && !bus.UpdatePC_Wen_SIMT_IF[i] && !w_init_hit[i] && !bus.Stall_IF;
        end
    end

    // Scanning once from the pointer: the first eligible hit is grant 1, the next one is grant 2.
    always_comb begin
        w_scan_idx = '0;
        w_g1_idx   = '0;
        w_g1_vld   = 1'b0;
`ifdef FETCH_DUAL_ISSUE_EN
        w_g2_idx   = '0;
        w_g2_vld   = 1'b0;
`endif
        for (int k = 0; k < NUM_WARPS; k++) begin
            w_scan_idx = r_rr_ptr + IDX_W'(k);
            if (w_elig[w_scan_idx] && !w_g1_vld) begin
                w_g1_idx = w_scan_idx;
                w_g1_vld = 1'b1;
            end
`ifdef FETCH_DUAL_ISSUE_EN
            else if (w_elig[w_scan_idx] && !w_g2_vld) begin
                w_g2_idx = w_scan_idx;
                w_g2_vld = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        w_grt1 = '0;
        w_grt2 = '0;
        if (w_g1_vld) w_grt1[w_g1_idx] = 1'b1;
`ifdef FETCH_DUAL_ISSUE_EN
        if (w_g2_vld) w_grt2[w_g2_idx] = 1'b1;
`endif
        w_grt_any = w_grt1 | w_grt2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
`ifdef FETCH_DUAL_ISSUE_EN
        end else if (w_g2_vld) begin
            r_rr_ptr <= w_g2_idx + 1'b1;
`endif
        end else if (w_g1_vld) begin
            r_rr_ptr <= w_g1_idx + 1'b1;
        end
    end

    // Init beats redirect beats advance; a redirect leaves the in-flight count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                r_pc[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                if (w_init_hit[i]) begin
                    r_pc[i]  <= bus.Init_PC;
                    r_cnt[i] <= '0;
                end else begin
                    if (bus.UpdatePC_Wen_SIMT_IF[i]) r_pc[i] <= bus.UpdatePC_SIMT_IF;
                    else if (w_grt_any[i])           r_pc[i] <= r_pc[i] + 32'd4;

                    if (w_grt_any[i])                r_cnt[i] <= LAT;
                    else if (r_cnt[i] != 2'd0)       r_cnt[i] <= r_cnt[i] - 2'd1;
                end
            end
        end
    end

    assign bus.GRT_raw_1_RR_IF = w_grt1;
    assign bus.GRT_raw_2_RR_IF = w_grt2;
    assign bus.PC0_PC_IF = r_pc[0];
    assign bus.PC1_PC_IF = r_pc[1];
    assign bus.PC2_PC_IF = r_pc[2];
    assign bus.PC3_PC_IF = r_pc[3];
    assign bus.PC4_PC_IF = r_pc[4];
    assign bus.PC5_PC_IF = r_pc[5];
    assign bus.PC6_PC_IF = r_pc[6];
    assign bus.PC7_PC_IF = r_pc[7];
endmodule

// File: tb/tb_warp_fetch_sched.sv
// Scoreboard bench for warp_fetch_sched: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_warp_fetch_sched;
`ifdef FETCH_DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    warp_fetch_sched_if #(.NUM_WARPS(8)) bus ();
    warp_fetch_sched #(.NUM_WARPS(8), .FETCH_LAT(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    string       q_nm [$];
    logic [7:0]  q_g1 [$];
    logic [7:0]  q_g2 [$];
    int          q_pw [$];
    logic [31:0] q_pc [$];
    int n_checks = 0;
    int n_err    = 0;

    function automatic logic [31:0] get_pc(input int w);
        case (w)
            0: return bus.PC0_PC_IF;
            1: return bus.PC1_PC_IF;
            2: return bus.PC2_PC_IF;
            3: return bus.PC3_PC_IF;
            4: return bus.PC4_PC_IF;
            5: return bus.PC5_PC_IF;
            6: return bus.PC6_PC_IF;
            default: return bus.PC7_PC_IF;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle against the settled outputs.
    always @(negedge clk) begin
        if (q_nm.size() > 0) begin
            string nm;
            int pw;
            logic [31:0] pc;
            logic [7:0] g1, g2;
            nm = q_nm.pop_front();
            g1 = q_g1.pop_front();
            g2 = q_g2.pop_front();
            pw = q_pw.pop_front();
            pc = q_pc.pop_front();
            chk({nm, ".grt1"}, {24'd0, bus.GRT_raw_1_RR_IF}, {24'd0, g1});
            chk({nm, ".grt2"}, {24'd0, bus.GRT_raw_2_RR_IF}, {24'd0, g2});
            if (pw >= 0) chk($sformatf("%s.pc%0d", nm, pw), get_pc(pw), pc);
        end
    end

    task automatic cyc(input string nm, input logic [7:0] g1, input logic [7:0] g2,
                       input int pw, input logic [31:0] pc);
        q_nm.push_back(nm);
        q_g1.push_back(g1);
        q_g2.push_back(g2);
        q_pw.push_back(pw);
        q_pc.push_back(pc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm, input int n, input int pw, input logic [31:0] pc);
        bus.PC_Valid = 8'h00;
        for (int i = 0; i < n; i++) cyc(nm, 8'h00, 8'h00, (i == 0) ? pw : -1, pc);
    endtask

    logic [7:0]  a_g1 [5];
    logic [7:0]  a_g2 [5];
    int          a_pw [5] = '{7, 0, 1, 2, 0};
    logic [31:0] a_pc [5] = '{32'h700, 32'h004, 32'h104, 32'h204, 32'h004};
    logic [31:0] p5;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if (DUAL) begin
            a_g1 = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h01};
            a_g2 = '{8'h02, 8'h08, 8'h20, 8'h80, 8'h02};
            p5   = 32'h504;
        end else begin
            a_g1 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
            a_g2 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
            p5   = 32'h500;
        end
        bus.PC_Valid = '0; bus.IBuf_Space_IB_IF = '0; bus.Stall_IF = 1'b0;
        bus.Init_Wen = 1'b0; bus.Init_WarpID = '0; bus.Init_PC = '0;
        bus.UpdatePC_Wen_SIMT_IF = '0; bus.UpdatePC_SIMT_IF = '0;
        @(posedge clk); #1;
        cyc("reset", 8'h00, 8'h00, 0, 32'h0);
        rst_n = 1'b1;

        // Launch all warps at 0x100*i.
        for (int i = 0; i < 8; i++) begin
            bus.Init_Wen = 1'b1; bus.Init_WarpID = 3'(i); bus.Init_PC = 32'h100 * i;
            cyc("init", 8'h00, 8'h00, i - 1, 32'h100 * (i - 1));
        end
        bus.Init_Wen = 1'b0;
        bus.PC_Valid = 8'hFF; bus.IBuf_Space_IB_IF = 8'hFF;
        for (int i = 0; i < 5; i++) cyc($sformatf("all%0d", i), a_g1[i], a_g2[i], a_pw[i], a_pc[i]);
        idle("idleA", 3, 0, DUAL ? 32'h008 : 32'h004);

        // Only warp 5 eligible: re-granted every third cycle.
        bus.PC_Valid = 8'h20;
        cyc("w5_1", 8'h20, 8'h00, 5, p5);
        cyc("w5_2", 8'h00, 8'h00, 5, p5 + 4);
        cyc("w5_3", 8'h00, 8'h00, 5, p5 + 4);
        cyc("w5_4", 8'h20, 8'h00, 5, p5 + 4);
        cyc("w5_5", 8'h00, 8'h00, 5, p5 + 8);
        cyc("w5_6", 8'h00, 8'h00, 5, p5 + 8);
        cyc("w5_7", 8'h20, 8'h00, 5, p5 + 8);
        idle("idleB", 2, 5, p5 + 12);

        // Redirect warp 2 in the cycle the pointer would reach it.
        bus.PC_Valid = 8'h0C;
        bus.UpdatePC_Wen_SIMT_IF = 8'h04; bus.UpdatePC_SIMT_IF = 32'h2000;
        cyc("redir1", 8'h08, 8'h00, 3, 32'h304);
        bus.UpdatePC_Wen_SIMT_IF = 8'h00;
        cyc("redir2", 8'h04, 8'h00, 2, 32'h2000);
        cyc("redir3", 8'h00, 8'h00, 2, 32'h2004);
        cyc("redir4", 8'h08, 8'h00, 3, 32'h308);
        cyc("redir5", 8'h04, 8'h00, 2, 32'h2004);
        idle("idleC", 3, 3, 32'h30C);

        // Init and redirect together: init wins; a later init clears the in-flight count.
        bus.PC_Valid = 8'h08;
        bus.Init_Wen = 1'b1; bus.Init_WarpID = 3'd3; bus.Init_PC = 32'h300;
        bus.UpdatePC_Wen_SIMT_IF = 8'h08; bus.UpdatePC_SIMT_IF = 32'h900;
        cyc("initred1", 8'h00, 8'h00, 3, 32'h30C);
        bus.Init_Wen = 1'b0; bus.UpdatePC_Wen_SIMT_IF = 8'h00;
        cyc("initred2", 8'h08, 8'h00, 3, 32'h300);
        bus.Init_Wen = 1'b1; bus.Init_PC = 32'h333;
        cyc("initclr1", 8'h00, 8'h00, 3, 32'h304);
        bus.Init_Wen = 1'b0;
        cyc("initclr2", 8'h08, 8'h00, 3, 32'h333);
        idle("idleD", 3, 3, 32'h337);

        // PC wrap at the top of the address space, then a four-cycle stall.
        bus.Init_Wen = 1'b1; bus.Init_WarpID = 3'd1; bus.Init_PC = 32'hFFFF_FFFC;
        cyc("wrap0", 8'h00, 8'h00, -1, 32'h0);
        bus.Init_Wen = 1'b0; bus.PC_Valid = 8'h02;
        cyc("wrap1", 8'h02, 8'h00, 1, 32'hFFFF_FFFC);
        bus.PC_Valid = 8'h00;
        cyc("wrap2", 8'h00, 8'h00, 1, 32'h0);
        bus.PC_Valid = 8'hFF; bus.Stall_IF = 1'b1;
        cyc("stall1", 8'h00, 8'h00, 1, 32'h0);
        cyc("stall2", 8'h00, 8'h00, 0, DUAL ? 32'h008 : 32'h004);
        cyc("stall3", 8'h00, 8'h00, 3, 32'h337);
        cyc("stall4", 8'h00, 8'h00, 2, 32'h2008);
        bus.Stall_IF = 1'b0;
        cyc("unstall", 8'h04, DUAL ? 8'h08 : 8'h00, 2, 32'h2008);
        bus.PC_Valid = 8'h00;
        cyc("after", 8'h00, 8'h00, 2, 32'h200C);

        // Asynchronous reset mid-run wipes everything.
        rst_n = 1'b0;
        cyc("rst2", 8'h00, 8'h00, 2, 32'h0);
        rst_n = 1'b1;
        bus.PC_Valid = 8'hFF;
        cyc("rst2_run", 8'h01, DUAL ? 8'h02 : 8'h00, 3, 32'h0);
        bus.PC_Valid = 8'h00;

        repeat (2) @(posedge clk);
        n_checks++;
        if (q_nm.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q_nm.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
